// File: rtl/aq_djpeg_pkg.sv
// Shared widths, bank ownership states and the level-shift/clamp helper
// used by the IDCT block buffer.
package aq_djpeg_pkg;

  localparam int DEF_IN_W      = 9;
  localparam int DEF_PIX_W     = 8;
  localparam int DEF_LVL_SHIFT = 128;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_DRAIN   = 2'd3
  } bank_state_t;

  // Integer form keeps the helper independent of the instance widths.
  function automatic int clamp_shift(input int sample, input int shift, input int max_val);
    int s;
    s = sample + shift;
    if (s < 0) return 0;
    if (s > max_val) return max_val;
    return s;
  endfunction

endpackage

// File: rtl/aq_djpeg_blkram.sv
// Two-bank 8x8 pixel store. Columns 0..3 and 4..7 live in separate arrays so
// the two samples of one beat are written in the same cycle.
module aq_djpeg_blkram #(
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [2:0]       wr_y,
  input  logic [1:0]       wr_k,
  input  logic [PIX_W-1:0] wr_data0,
  input  logic [PIX_W-1:0] wr_data1,
  input  logic             rd_en,
  input  logic             rd_bank,
  input  logic [2:0]       rd_y,
  input  logic [2:0]       rd_x,
  output logic [PIX_W-1:0] rd_data
);

  logic [1:0][PIX_W-1:0] wr_half;
  logic [1:0][PIX_W-1:0] half_q;
  logic                  sel_reg;

  assign wr_half = {wr_data1, wr_data0};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_half
      logic [PIX_W-1:0] mem [0:63];
      logic [PIX_W-1:0] q_reg;
      logic [1:0]       wr_idx;

      // Data1 sits at x = 7-k, i.e. index ~k inside the upper half.
      assign wr_idx = (gi == 0) ? wr_k : ~wr_k;

      always_ff @(posedge clk) begin
        if (wr_en) mem[{wr_bank, wr_y, wr_idx}] <= wr_half[gi];
        if (rd_en) q_reg <= mem[{rd_bank, rd_y, rd_x[1:0]}];
      end

      assign half_q[gi] = q_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rd_en) sel_reg <= rd_x[2];
  end

  assign rd_data = half_q[sel_reg];

endmodule

// File: rtl/aq_djpeg_idct_blkbuf.sv
// IDCT output block buffer: level-shift/clamp, ping-pong 8x8 storage and a
// raster pixel stream with valid/ready back-pressure.
module aq_djpeg_idct_blkbuf
  import aq_djpeg_pkg::*;
#(
  parameter int IN_W      = DEF_IN_W,
  parameter int PIX_W     = DEF_PIX_W,
  parameter int LVL_SHIFT = DEF_LVL_SHIFT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ProcessInit,
  input  logic             DataInEnable,
  input  logic [2:0]       DataInPage,
  input  logic [1:0]       DataInCount,
  input  logic [IN_W-1:0]  Data0In,
  input  logic [IN_W-1:0]  Data1In,
  output logic             DataInIdle,
  output logic             DataOutValid,
  input  logic             DataOutReady,
  output logic [PIX_W-1:0] DataOutPixel,
  output logic [2:0]       DataOutX,
  output logic [2:0]       DataOutY,
  output logic             DataOutLast,
  output logic             Overflow
);

  logic        clr;
  bank_state_t bank_reg [2];
  bank_state_t bank_next [2];
  logic        wr_bank_reg;
  logic [4:0]  wr_cnt_reg;
  logic        iss_bank_reg;
  logic [5:0]  iss_cnt_reg;
  logic        rd_bank_reg;

  logic        s1_valid_reg;
  logic [2:0]  s1_x_reg;
  logic [2:0]  s1_y_reg;
  logic        s1_last_reg;

  logic             out_valid_reg;
  logic [PIX_W-1:0] out_pix_reg;
  logic [2:0]       out_x_reg;
  logic [2:0]       out_y_reg;
  logic             out_last_reg;
  logic             overflow_reg;

  bank_state_t      wr_state;
  bank_state_t      iss_state;
  logic             free_bank;
  logic             wr_free_hit;
  logic             wr_open;
  logic             wr_accept;
  logic             iss_start;
  logic             iss_fire;
  logic             s2_load;
  logic [PIX_W-1:0] pix0;
  logic [PIX_W-1:0] pix1;
  logic [PIX_W-1:0] ram_rd_data;

  assign clr = rst | ProcessInit;

  assign pix0 = PIX_W'(clamp_shift(int'($signed(Data0In)), LVL_SHIFT, (1 << PIX_W) - 1));
  assign pix1 = PIX_W'(clamp_shift(int'($signed(Data1In)), LVL_SHIFT, (1 << PIX_W) - 1));

  assign wr_state    = bank_reg[wr_bank_reg];
  assign iss_state   = bank_reg[iss_bank_reg];
  assign free_bank   = out_valid_reg & DataOutReady & out_last_reg;
  // A bank released by the reader this cycle may already take the next beat.
  assign wr_free_hit = free_bank & (rd_bank_reg == wr_bank_reg);
  assign wr_open     = (wr_state == BANK_EMPTY) | (wr_state == BANK_FILLING) | wr_free_hit;
  assign wr_accept   = DataInEnable & wr_open & ~clr;

  assign iss_start = (iss_state == BANK_FULL);
  assign s2_load   = s1_valid_reg & (~out_valid_reg | DataOutReady);
  // The issue side runs ahead of the output so the next bank can start
  // before the previous bank's last pixel has been accepted.
  assign iss_fire  = (iss_state == BANK_DRAIN) & (~s1_valid_reg | s2_load);

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_next[b] = bank_reg[b];
      if (iss_start && (iss_bank_reg == b[0])) bank_next[b] = BANK_DRAIN;
      if (free_bank && (rd_bank_reg == b[0])) bank_next[b] = BANK_EMPTY;
      if (wr_accept && (wr_bank_reg == b[0]))
        bank_next[b] = (wr_cnt_reg == 5'd31) ? BANK_FULL : BANK_FILLING;
    end
  end

  aq_djpeg_blkram #(
    .PIX_W(PIX_W)
  ) u_ram (
    .clk      (clk),
    .wr_en    (wr_accept),
    .wr_bank  (wr_bank_reg),
    .wr_y     (DataInPage),
    .wr_k     (DataInCount),
    .wr_data0 (pix0),
    .wr_data1 (pix1),
    .rd_en    (iss_fire),
    .rd_bank  (iss_bank_reg),
    .rd_y     (iss_cnt_reg[5:3]),
    .rd_x     (iss_cnt_reg[2:0]),
    .rd_data  (ram_rd_data)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      bank_reg      <= '{BANK_EMPTY, BANK_EMPTY};
      wr_bank_reg   <= 1'b0;
      wr_cnt_reg    <= '0;
      iss_bank_reg  <= 1'b0;
      iss_cnt_reg   <= '0;
      rd_bank_reg   <= 1'b0;
      s1_valid_reg  <= 1'b0;
      s1_x_reg      <= '0;
      s1_y_reg      <= '0;
      s1_last_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      out_pix_reg   <= '0;
      out_x_reg     <= '0;
      out_y_reg     <= '0;
      out_last_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      bank_reg <= bank_next;

      if (wr_accept) begin
        wr_cnt_reg <= wr_cnt_reg + 5'd1;
        if (wr_cnt_reg == 5'd31) wr_bank_reg <= ~wr_bank_reg;
      end

      if (iss_fire) begin
        iss_cnt_reg  <= iss_cnt_reg + 6'd1;
        if (&iss_cnt_reg) iss_bank_reg <= ~iss_bank_reg;
        s1_valid_reg <= 1'b1;
        s1_x_reg     <= iss_cnt_reg[2:0];
        s1_y_reg     <= iss_cnt_reg[5:3];
        s1_last_reg  <= &iss_cnt_reg;
      end else if (s2_load) begin
        s1_valid_reg <= 1'b0;
      end

      if (s2_load) begin
        out_valid_reg <= 1'b1;
        out_pix_reg   <= ram_rd_data;
        out_x_reg     <= s1_x_reg;
        out_y_reg     <= s1_y_reg;
        out_last_reg  <= s1_last_reg;
      end else if (DataOutReady) begin
        out_valid_reg <= 1'b0;
      end

      if (free_bank) rd_bank_reg <= ~rd_bank_reg;
      if (DataInEnable && !wr_open) overflow_reg <= 1'b1;
    end
  end

  assign DataInIdle   = (wr_state == BANK_EMPTY) | (wr_state == BANK_FILLING);
  assign DataOutValid = out_valid_reg;
  assign DataOutPixel = out_pix_reg;
  assign DataOutX     = out_x_reg;
  assign DataOutY     = out_y_reg;
  assign DataOutLast  = out_last_reg;
  assign Overflow     = overflow_reg;

endmodule
